mux_stream_packer: RTL and testbench

Downstream consumer of the registered 2-bit 2:1 multiplexer stage. Collects consecutive 2-bit mux output symbols into packed words and holds them in a small show-ahead FIFO for a ready/valid consumer. Upstream has no backpressure: the mux registers a new value every cycle. When the FIFO cannot accept a completed word, the word is dropped and a sticky overflow flag is raised.

---
 rtl/mux_stream_packer.sv | 166 ++++++++++++++++
 tb/tb_mux_stream_packer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mux_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : mux_stream_packer
// Description : Packs consecutive 2-bit mux symbols LSB-first into words of
//               SYMBOLS symbols and queues them in a show-ahead FIFO for a
//               ready/valid consumer. When the FIFO has no room for a word,
//               that word is dropped and a sticky overflow flag is raised.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_stream_packer #(
  parameter int SYMBOLS = 4,
  parameter int DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [1:0]                   data_in,
  input  logic                         ready_out,
  output logic [2*SYMBOLS-1:0]         data_out,
  output logic                         valid_out,
  output logic [$clog2(DEPTH):0]       occupancy,
  output logic [$clog2(SYMBOLS)-1:0]   sym_count,
  output logic                         overflow
);

  localparam int W  = 2 * SYMBOLS;
  localparam int CW = $clog2(SYMBOLS);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_PARTIAL = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;

  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_sym_count;
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [OW-1:0] r_occ;
  logic [W-1:0]  r_data_out;
  logic          r_overflow;
  logic [1:0]    r_state;

  logic [1:0]    w_state_next;
  logic [W-1:0]  w_word;
  logic          w_last;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;
  logic [PW-1:0] w_rd_next;
  logic [OW-1:0] w_occ_next;

  // The completed word takes the live symbol in its slot, so the final
  // symbol does not have to pass through the accumulator first.
  genvar k;
  generate
    for (k = 0; k < SYMBOLS; k++) begin : g_slot
      assign w_word[2*k +: 2] = (r_sym_count == CW'(k)) ? data_in : r_acc[2*k +: 2];
    end
  endgenerate

  assign w_last    = valid_in && (r_sym_count == CW'(SYMBOLS - 1));
  assign w_pop     = valid_out && ready_out;
  assign w_push_ok = w_last && (!w_full || w_pop);
  assign w_drop    = w_last && w_full && !w_pop;
  assign w_rd_next = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;

  // Next occupancy from the accepted push and the pop.
  always_comb begin
    w_occ_next = r_occ;
    if (w_push_ok && !w_pop) begin
      w_occ_next = r_occ + OW'(1);
    end else if (!w_push_ok && w_pop) begin
      w_occ_next = r_occ - OW'(1);
    end
  end

  // Partial-word accumulator and symbol counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_sym_count <= '0;
    end else if (valid_in) begin
      r_acc       <= w_last ? '0 : w_word;
      r_sym_count <= w_last ? '0 : r_sym_count + CW'(1);
    end
  end

  // FIFO storage write; entries carry no reset because occupancy guards them.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // Pointers, occupancy, registered head word and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_data_out <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_occ    <= w_occ_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      // The new head is the incoming word only when the read pointer lands on
      // the slot being written this cycle; otherwise it is already in memory.
      if (w_occ_next == '0) begin
        r_data_out <= '0;
      end else if (w_push_ok && (w_rd_next == r_wr_ptr)) begin
        r_data_out <= w_word;
      end else begin
        r_data_out <= r_mem[w_rd_next];
      end
    end
  end

  // FIFO status state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FIFO status next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_push_ok && !w_pop) w_state_next = S_PARTIAL;
      end
      S_PARTIAL: begin
        if (w_occ_next == OW'(DEPTH))  w_state_next = S_FULL;
        else if (w_occ_next == '0)     w_state_next = S_EMPTY;
      end
      S_FULL: begin
        if (w_pop && !w_push_ok) w_state_next = S_PARTIAL;
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  // FIFO status outputs decoded from the state register.
  always_comb begin
    valid_out = (r_state != S_EMPTY);
    w_full    = (r_state == S_FULL);
  end

  assign data_out  = r_data_out;
  assign occupancy = r_occ;
  assign sym_count = r_sym_count;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mux_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_stream_packer
// Description : Directed self-checking bench for mux_stream_packer
//               (SYMBOLS=4, DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_stream_packer;

  logic       clk;
  logic       reset;
  logic       valid_in;
  logic [1:0] data_in;
  logic       ready_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] occupancy;
  logic [1:0] sym_count;
  logic       overflow;

  int total;
  int bad;

  mux_stream_packer #(.SYMBOLS(4), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .occupancy (occupancy),
    .sym_count (sym_count),
    .overflow  (overflow)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [1:0] d, input logic r);
    valid_in  = v;
    data_in   = d;
    ready_out = r;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle, outputs checked while held.
  task automatic do_reset(input string tag);
    valid_in  = 1'b0;
    ready_out = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk({tag, "_rst_data"},  32'(data_out),  32'h0);
    chk({tag, "_rst_valid"}, 32'(valid_out), 32'h0);
    chk({tag, "_rst_occ"},   32'(occupancy), 32'h0);
    chk({tag, "_rst_sym"},   32'(sym_count), 32'h0);
    chk({tag, "_rst_ovf"},   32'(overflow),  32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    valid_in  = 1'b0;
    data_in   = 2'b00;
    ready_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("init_valid", 32'(valid_out), 32'h0);
    chk("init_data",  32'(data_out),  32'h0);

    // Basic pack: 01,10,11,00 -> 8'h39
    step(1'b1, 2'b01, 1'b0); chk("basic_sym1", 32'(sym_count), 32'd1);
    chk("basic_novalid", 32'(valid_out), 32'h0);
    step(1'b1, 2'b10, 1'b0); chk("basic_sym2", 32'(sym_count), 32'd2);
    step(1'b1, 2'b11, 1'b0); chk("basic_sym3", 32'(sym_count), 32'd3);
    step(1'b1, 2'b00, 1'b0); chk("basic_sym0", 32'(sym_count), 32'd0);
    chk("basic_data",  32'(data_out),  32'h39);
    chk("basic_valid", 32'(valid_out), 32'h1);
    chk("basic_occ",   32'(occupancy), 32'd1);
    // Held head while not ready
    step(1'b0, 2'b00, 1'b0); chk("basic_hold", 32'(data_out), 32'h39);

    // Gapped input
    do_reset("gap");
    step(1'b1, 2'b01, 1'b0);
    repeat (3) step(1'b0, 2'b11, 1'b0);
    chk("gap_sym_hold", 32'(sym_count), 32'd1);
    step(1'b1, 2'b10, 1'b0);
    repeat (3) step(1'b0, 2'b11, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    repeat (3) step(1'b0, 2'b01, 1'b0);
    chk("gap_sym3", 32'(sym_count), 32'd3);
    chk("gap_novalid", 32'(valid_out), 32'h0);
    step(1'b1, 2'b00, 1'b0);
    chk("gap_data", 32'(data_out),  32'h39);
    chk("gap_occ",  32'(occupancy), 32'd1);
    repeat (3) step(1'b0, 2'b00, 1'b0);
    chk("gap_occ_after", 32'(occupancy), 32'd1);

    // Overflow: 12 symbols of 11 with no consumer
    do_reset("ovf");
    repeat (8) step(1'b1, 2'b11, 1'b0);
    chk("ovf_occ8",  32'(occupancy), 32'd2);
    chk("ovf_data8", 32'(data_out),  32'hFF);
    chk("ovf_flag8", 32'(overflow),  32'h0);
    repeat (3) step(1'b1, 2'b11, 1'b0);
    chk("ovf_flag11", 32'(overflow), 32'h0);
    step(1'b1, 2'b11, 1'b0);
    chk("ovf_flag12", 32'(overflow),  32'h1);
    chk("ovf_occ12",  32'(occupancy), 32'd2);
    step(1'b0, 2'b00, 1'b0);
    chk("ovf_sticky", 32'(overflow),  32'h1);

    // Simultaneous push/pop at full
    do_reset("pp");
    step(1'b1, 2'b01, 1'b0); step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b01, 1'b0); step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b10, 1'b0); step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b10, 1'b0); step(1'b1, 2'b00, 1'b0);
    chk("pp_full_occ",  32'(occupancy), 32'd2);
    chk("pp_full_head", 32'(data_out),  32'h11);
    step(1'b1, 2'b11, 1'b0); step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b00, 1'b1);
    chk("pp_occ",  32'(occupancy), 32'd2);
    chk("pp_ovf",  32'(overflow),  32'h0);
    chk("pp_head", 32'(data_out),  32'h22);
    step(1'b0, 2'b00, 1'b1);
    chk("pp_pop1", 32'(data_out),  32'h33);
    chk("pp_occ1", 32'(occupancy), 32'd1);
    step(1'b0, 2'b00, 1'b1);
    chk("pp_pop2_valid", 32'(valid_out), 32'h0);
    chk("pp_pop2_data",  32'(data_out),  32'h0);
    // Pop request while empty is ignored
    step(1'b0, 2'b00, 1'b1);
    chk("pp_empty_occ", 32'(occupancy), 32'd0);

    // Reset mid-word
    do_reset("mw_pre");
    step(1'b1, 2'b11, 1'b0); step(1'b1, 2'b11, 1'b0);
    chk("mw_sym2", 32'(sym_count), 32'd2);
    do_reset("mw");
    step(1'b1, 2'b01, 1'b0); step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b01, 1'b0); step(1'b1, 2'b01, 1'b0);
    chk("mw_data", 32'(data_out),  32'h55);
    chk("mw_occ",  32'(occupancy), 32'd1);

    // Drain and wrap: words 00..04 with consumer always ready
    do_reset("dw");
    for (int w = 0; w < 5; w++) begin
      logic [7:0] word;
      word = 8'(w);
      for (int s = 0; s < 4; s++) begin
        step(1'b1, word[2*s +: 2], 1'b1);
      end
      chk($sformatf("dw_word%0d", w), 32'(data_out),  32'(w));
      chk($sformatf("dw_occ%0d", w),  32'(occupancy), 32'd1);
    end
    step(1'b0, 2'b00, 1'b1);
    chk("dw_end_occ",   32'(occupancy), 32'd0);
    chk("dw_end_valid", 32'(valid_out), 32'h0);
    chk("dw_end_ovf",   32'(overflow),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
